// File: rtl/uart_frame_rx.sv
// Length-prefixed UART frame receiver. Bytes are buffered until the frame is
// complete, then drained downstream over a valid/ready handshake.
module uart_frame_rx #(
    parameter int CLOCK_FREQUENCY = 48_000_000,
    parameter int BAUDRATE        = 115_200,
    parameter int MAX_PAYLOAD     = 64,
    parameter int TIMEOUT_BITS    = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       last,
    input  logic       ready,
    output logic [7:0] frame_length,
    output logic       frame_done,
    output logic       frame_error,
    output logic [1:0] error_code
);
    localparam int DIVIDER     = CLOCK_FREQUENCY / BAUDRATE;
    localparam int HALF        = DIVIDER / 2;
    localparam int CNT_W       = $clog2(DIVIDER + 1);
    localparam int TIMEOUT_CYC = TIMEOUT_BITS * DIVIDER;
    localparam int TO_W        = $clog2(TIMEOUT_CYC + 1);
    localparam int IDX_W       = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

    // rxSyncQ is only the previous synchronized value, used for edge detection
    logic rxMeta, rxSync, rxSyncQ, rxFall;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rxMeta  <= 1'b1;
            rxSync  <= 1'b1;
            rxSyncQ <= 1'b1;
        end else begin
            rxMeta  <= rx;
            rxSync  <= rxMeta;
            rxSyncQ <= rxSync;
        end
    end
    assign rxFall = rxSyncQ & ~rxSync;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rxState_t;
    rxState_t rxState, rxNext;
    logic [CNT_W-1:0] bitCnt;
    logic [2:0]       bitIdx;
    logic [7:0]       shiftReg;
    logic             stopWait;
    logic halfTick, bitTick, stopTick, byteStrobe, stopErr;

    assign halfTick   = (rxState == START) && (bitCnt == CNT_W'(HALF - 1));
    assign bitTick    = (bitCnt == CNT_W'(DIVIDER - 1));
    assign stopTick   = (rxState == STOP) && !stopWait && bitTick;
    assign byteStrobe = stopTick && rxSync;
    assign stopErr    = stopTick && !rxSync;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rxState <= IDLE;
        else        rxState <= rxNext;
    end

    always_comb begin
        rxNext = rxState;
        case (rxState)
            IDLE:  if (rxFall) rxNext = START;
            START: if (halfTick) rxNext = rxSync ? IDLE : DATA;
            DATA:  if (bitTick && bitIdx == 3'd7) rxNext = STOP;
            STOP:  if (byteStrobe || (stopWait && rxSync)) rxNext = IDLE;
            default: rxNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bitCnt   <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            stopWait <= 1'b0;
        end else begin
            bitCnt <= (rxState != rxNext || bitTick) ? '0 : bitCnt + 1'b1;
            if (rxState == DATA && bitTick) begin
                shiftReg <= {rxSync, shiftReg[7:1]};
                bitIdx   <= bitIdx + 1'b1;
            end
            // a low stop bit parks the receiver until the line returns high
            if (stopErr)              stopWait <= 1'b1;
            else if (rxNext == IDLE)  stopWait <= 1'b0;
        end
    end

    typedef enum logic [1:0] {WAIT_LEN, PAYLOAD, DRAIN} frState_t;
    frState_t frState, frNext;
    logic [7:0]       payLen;
    logic [IDX_W-1:0] wrIdx, rdIdx, lastIdx;
    logic [TO_W-1:0]  toCnt;
    logic [7:0]       buffer [MAX_PAYLOAD];
    logic lenOk, timeoutHit, payloadEnd, xfer;

    assign lenOk      = (shiftReg != 8'd0) && (shiftReg <= 8'(MAX_PAYLOAD));
    assign lastIdx    = IDX_W'(payLen - 8'd1);
    assign timeoutHit = (frState == PAYLOAD) && !byteStrobe && (toCnt == TO_W'(TIMEOUT_CYC - 1));
    assign payloadEnd = (frState == PAYLOAD) && byteStrobe && (wrIdx == lastIdx);
    assign valid      = (frState == DRAIN);
    assign last       = valid && (rdIdx == lastIdx);
    assign data       = valid ? buffer[rdIdx] : 8'd0;
    assign xfer       = valid && ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) frState <= WAIT_LEN;
        else        frState <= frNext;
    end

    always_comb begin
        frNext = frState;
        case (frState)
            WAIT_LEN: if (byteStrobe && lenOk) frNext = PAYLOAD;
            PAYLOAD:  if (stopErr || timeoutHit) frNext = WAIT_LEN;
                      else if (payloadEnd)       frNext = DRAIN;
            DRAIN:    if (xfer && last) frNext = WAIT_LEN;
            default:  frNext = WAIT_LEN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (frState == PAYLOAD && byteStrobe) buffer[wrIdx] <= shiftReg;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            payLen       <= '0;
            wrIdx        <= '0;
            rdIdx        <= '0;
            toCnt        <= '0;
            frame_length <= '0;
            frame_done   <= 1'b0;
            frame_error  <= 1'b0;
            error_code   <= 2'd0;
        end else begin
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            toCnt <= (frState == PAYLOAD && !byteStrobe) ? toCnt + 1'b1 : '0;
            case (frState)
                WAIT_LEN: begin
                    if (byteStrobe && lenOk) begin
                        payLen <= shiftReg;
                        wrIdx  <= '0;
                    end else if (byteStrobe) begin
                        frame_error <= 1'b1;
                        error_code  <= 2'd1;
                    end else if (stopErr) begin
                        frame_error <= 1'b1;
                        error_code  <= 2'd2;
                    end
                end
                PAYLOAD: begin
                    if (stopErr) begin
                        frame_error <= 1'b1;
                        error_code  <= 2'd2;
                    end else if (timeoutHit) begin
                        frame_error <= 1'b1;
                        error_code  <= 2'd3;
                    end else if (byteStrobe) begin
                        wrIdx <= wrIdx + 1'b1;
                        if (payloadEnd) begin
                            frame_done   <= 1'b1;
                            frame_length <= payLen;
                            rdIdx        <= '0;
                        end
                    end
                end
                DRAIN: begin
                    // any byte finishing while the buffer is busy is an overrun
                    if (stopTick) begin
                        frame_error <= 1'b1;
                        error_code  <= 2'd3;
                    end
                    if (xfer) begin
                        if (last) frame_length <= '0;
                        else      rdIdx <= rdIdx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx with a 16-cycle bit period.
module tb_uart_frame_rx;
    localparam int BIT = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid, last;
    logic [7:0] frame_length;
    logic       frame_done, frame_error;
    logic [1:0] error_code;

    uart_frame_rx #(
        .CLOCK_FREQUENCY(160),
        .BAUDRATE(10),
        .MAX_PAYLOAD(64),
        .TIMEOUT_BITS(20)
    ) dut (
        .clock(clock), .reset(reset), .rx(rx),
        .data(data), .valid(valid), .last(last), .ready(ready),
        .frame_length(frame_length), .frame_done(frame_done),
        .frame_error(frame_error), .error_code(error_code)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // toggling ready changes #1 after the rising edge so negedge sampling is clean
    bit toggleReady = 1'b0;
    always @(posedge clock) begin
        #1;
        if (toggleReady) ready = ~ready;
    end

    logic [7:0] xData[$];
    logic       xLast[$];
    logic [1:0] errCodes[$];
    logic [7:0] expB[$];
    int         doneCnt = 0;
    logic [7:0] lenAtDone = 8'd0;
    logic       hValid = 1'b0, hReady = 1'b0;
    logic [7:0] hData = 8'd0;

    always @(negedge clock) begin
        if (reset) begin
            if (hValid && !hReady) begin
                chk("hold valid", {31'd0, valid}, 32'd1);
                chk("hold data", {24'd0, data}, {24'd0, hData});
            end
            if (valid && ready) begin
                xData.push_back(data);
                xLast.push_back(last);
            end
            if (frame_done) begin
                doneCnt++;
                lenAtDone = frame_length;
            end
            if (frame_error) errCodes.push_back(error_code);
        end
        hValid = valid && reset;
        hReady = ready;
        hData  = data;
    end

    task automatic bitTime(input logic v);
        @(negedge clock) rx = v;
        repeat (BIT - 1) @(negedge clock);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopV);
        bitTime(1'b0);
        for (int i = 0; i < 8; i++) bitTime(b[i]);
        bitTime(stopV);
        bitTime(1'b1);
    endtask

    task automatic sendExpFrame();
        sendByte(8'(expB.size()), 1'b1);
        for (int i = 0; i < expB.size(); i++) sendByte(expB[i], 1'b1);
    endtask

    task automatic clearLog();
        xData.delete();
        xLast.delete();
        errCodes.delete();
        doneCnt = 0;
    endtask

    task automatic chkFrame(input string tag);
        chk({tag, " count"}, xData.size(), expB.size());
        chk({tag, " done"}, doneCnt, 1);
        for (int i = 0; i < expB.size() && i < xData.size(); i++) begin
            chk($sformatf("%s data[%0d]", tag, i), {24'd0, xData[i]}, {24'd0, expB[i]});
            chk($sformatf("%s last[%0d]", tag, i), {31'd0, xLast[i]}, {31'd0, i == expB.size() - 1});
        end
    endtask

    task automatic chkResetOutputs(input string tag);
        chk({tag, " valid"}, {31'd0, valid}, 32'd0);
        chk({tag, " last"}, {31'd0, last}, 32'd0);
        chk({tag, " data"}, {24'd0, data}, 32'd0);
        chk({tag, " frame_length"}, {24'd0, frame_length}, 32'd0);
        chk({tag, " frame_done"}, {31'd0, frame_done}, 32'd0);
        chk({tag, " frame_error"}, {31'd0, frame_error}, 32'd0);
        chk({tag, " error_code"}, {30'd0, error_code}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chkResetOutputs("reset");
        @(negedge clock) reset = 1'b1;
        repeat (5) @(negedge clock);

        // full 64-byte frame, ready held high
        for (int i = 1; i <= 64; i++) expB.push_back(8'(i));
        sendExpFrame();
        repeat (200) @(negedge clock);
        chkFrame("f64");
        chk("f64 len", {24'd0, lenAtDone}, 32'd64);
        chk("f64 len cleared", {24'd0, frame_length}, 32'd0);
        chk("f64 errors", errCodes.size(), 0);
        chk("f64 code", {30'd0, error_code}, 32'd0);

        // same frame, ready toggling
        clearLog();
        toggleReady = 1'b1;
        sendExpFrame();
        repeat (300) @(negedge clock);
        toggleReady = 1'b0;
        @(negedge clock) ready = 1'b1;
        chkFrame("f64 toggle");
        chk("toggle errors", errCodes.size(), 0);

        // bad lengths then a good 3-byte frame
        clearLog();
        sendByte(8'd0, 1'b1);
        sendByte(8'd65, 1'b1);
        repeat (20) @(negedge clock);
        chk("badlen errors", errCodes.size(), 2);
        if (errCodes.size() == 2) begin
            chk("badlen code0", {30'd0, errCodes[0]}, 32'd1);
            chk("badlen code1", {30'd0, errCodes[1]}, 32'd1);
        end
        chk("badlen no valid", xData.size(), 0);
        clearLog();
        expB = '{8'hA5, 8'h5A, 8'hFF};
        sendExpFrame();
        repeat (40) @(negedge clock);
        chkFrame("f3");
        chk("f3 code kept", {30'd0, error_code}, 32'd1);

        // timeout after 2 of 5 bytes
        clearLog();
        sendByte(8'd5, 1'b1);
        sendByte(8'h11, 1'b1);
        sendByte(8'h22, 1'b1);
        repeat (25 * BIT) @(negedge clock);
        chk("timeout errors", errCodes.size(), 1);
        if (errCodes.size() == 1) chk("timeout code", {30'd0, errCodes[0]}, 32'd3);
        chk("timeout no done", doneCnt, 0);
        clearLog();
        expB = '{8'h33, 8'h44};
        sendExpFrame();
        repeat (40) @(negedge clock);
        chkFrame("f2");

        // stop bit low inside payload, then a quarter-bit glitch
        clearLog();
        sendByte(8'd4, 1'b1);
        sendByte(8'h77, 1'b0);
        repeat (20) @(negedge clock);
        chk("stop errors", errCodes.size(), 1);
        if (errCodes.size() == 1) chk("stop code", {30'd0, errCodes[0]}, 32'd2);
        clearLog();
        @(negedge clock) rx = 1'b0;
        repeat (BIT / 4) @(negedge clock);
        rx = 1'b1;
        repeat (12 * BIT) @(negedge clock);
        chk("glitch errors", errCodes.size(), 0);
        expB = '{8'h9C};
        sendExpFrame();
        repeat (40) @(negedge clock);
        chkFrame("f1");
        chk("glitch errors after", errCodes.size(), 0);
        chk("f1 code kept", {30'd0, error_code}, 32'd2);

        // reset during byte 10 of a 64-byte frame
        clearLog();
        sendByte(8'd64, 1'b1);
        for (int i = 1; i <= 9; i++) sendByte(8'(i), 1'b1);
        @(negedge clock) rx = 1'b0;
        repeat (3 * BIT) @(negedge clock);
        reset = 1'b0;
        #1;
        chkResetOutputs("midreset");
        rx = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        expB = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        sendExpFrame();
        repeat (40) @(negedge clock);
        chkFrame("f4");
        chk("f4 errors", errCodes.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
